// File: rtl/ifu_prefetch.sv
// ifu_prefetch: sequential instruction fetch with a prefetch FIFO and up to
// DEPTH outstanding reads on an AR/R channel. PC redirects flush the FIFO and
// drop responses to requests issued before the redirect.
// Optional feature macro: IFU_PREFETCH_RESP_ERR_EN turns a non-OKAY RRESP into
// a NOP entry flagged with instr_err and halts fetching until the next redirect.
module ifu_prefetch #(
    parameter int AW = 64,
    parameter int IW = 32,
    parameter int DEPTH = 4,
    parameter logic [AW-1:0] RST_PC = 64'h8000_0000
) (
    input  logic          clk,
    input  logic          rstn,
    output logic          ifu_ARVALID,
    input  logic          ifu_ARREADY,
    output logic [AW-1:0] ifu_ARADDR,
    output logic [2:0]    ifu_ARPORT,
    input  logic          ifu_RVALID,
    output logic          ifu_RREADY,
    input  logic [63:0]   ifu_RDATA,
    input  logic [1:0]    ifu_RRESP,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic [IW-1:0] instr,
    output logic [AW-1:0] instr_pc,
    output logic          instr_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]    state;
    logic [AW-1:0] fetch_pc;
    logic [AW-1:0] rsp_pc;
    logic [AW-1:0] hold_addr;
    logic          ar_hold;
    logic          hold_stale;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] stale_cnt;

    logic [DEPTH-1:0] lane_q;
    logic [PW-1:0]    lq_wr;
    logic [PW-1:0]    lq_rd;

    logic [AW-1:0] pc_mem   [DEPTH];
    logic [IW-1:0] instr_mem[DEPTH];
    logic          err_mem  [DEPTH];
    logic [CW-1:0] wptr;
    logic [CW-1:0] rptr;

    logic [CW-1:0] fifo_count;
    logic [CW:0]   credit_used;
    logic [CW-1:0] out_next;
    logic [CW-1:0] stale_next;
    logic          hold_stale_next;
    logic          issue_ok;
    logic          ar_fire;
    logic          r_fire;
    logic          r_stale;
    logic          push;
    logic          pop;
    logic          redirect_act;
    logic          r_lane;
    logic          r_err;
    logic          err_stop;
    logic [AW-1:0] ar_addr_sel;
    logic [AW-1:0] redirect_aligned;
    logic [IW-1:0] r_instr;
    logic [IW-1:0] push_instr;
    logic          unused_bits;

    assign fifo_count  = wptr - rptr;
    assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding};
    assign issue_ok    = (state == FETCH) && !ar_hold && !err_stop && (credit_used < DEPTH_C);

    assign ar_addr_sel = ar_hold ? hold_addr : fetch_pc;
    assign ifu_ARVALID = ar_hold || issue_ok;
    assign ifu_ARADDR  = ifu_ARVALID ? ar_addr_sel : '0;
    assign ifu_ARPORT  = ifu_ARVALID ? 3'b100 : 3'b000;
    assign ifu_RREADY  = 1'b1;

    assign ar_fire      = ifu_ARVALID && ifu_ARREADY;
    assign r_fire       = ifu_RVALID && (outstanding != '0);
    assign redirect_act = redirect_valid && (state != IDLE);
    assign redirect_aligned = {redirect_pc[AW-1:2], 2'b00};
    assign unused_bits  = ^redirect_pc[1:0];

    assign r_lane  = lane_q[lq_rd];
    assign r_instr = r_lane ? ifu_RDATA[63:32] : ifu_RDATA[31:0];
    assign r_stale = (stale_cnt != '0) || (state != FETCH);
    assign push    = r_fire && !r_stale && !redirect_act;
    assign pop     = instr_valid && instr_ready;

    assign instr_valid = (fifo_count != '0);
    assign instr       = instr_valid ? instr_mem[rptr[PW-1:0]] : '0;
    assign instr_pc    = instr_valid ? pc_mem[rptr[PW-1:0]] : '0;
    assign instr_err   = instr_valid ? err_mem[rptr[PW-1:0]] : 1'b0;

`ifdef IFU_PREFETCH_RESP_ERR_EN
    assign r_err      = (ifu_RRESP != 2'b00);
    assign push_instr = r_err ? IW'(32'h0000_0013) : r_instr;

    // Latch a fetch halt after an errored entry is queued; a redirect releases it.
    always_ff @(posedge clk) begin
        if (!rstn)
            err_stop <= 1'b0;
        else if (redirect_act)
            err_stop <= 1'b0;
        else if (push && r_err)
            err_stop <= 1'b1;
    end
`else
    logic unused_resp;
    assign unused_resp = ^ifu_RRESP;
    assign r_err       = 1'b0;
    assign err_stop    = 1'b0;
    assign push_instr  = r_instr;
`endif

    // Next outstanding/stale bookkeeping; a redirect makes every in-flight or held request stale.
    always_comb begin
        out_next        = outstanding + CW'(ar_fire) - CW'(r_fire);
        stale_next      = stale_cnt;
        hold_stale_next = hold_stale;
        if (redirect_act) begin
            stale_next      = out_next;
            hold_stale_next = ifu_ARVALID && !ifu_ARREADY;
        end else begin
            stale_next      = stale_cnt - CW'(r_fire && (stale_cnt != '0)) + CW'(ar_fire && hold_stale);
            hold_stale_next = hold_stale && !ar_fire;
        end
    end

    // Fetch control: state machine, fetch/response PCs, AR hold and stale accounting.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= IDLE;
            fetch_pc    <= '0;
            rsp_pc      <= '0;
            hold_addr   <= '0;
            ar_hold     <= 1'b0;
            hold_stale  <= 1'b0;
            outstanding <= '0;
            stale_cnt   <= '0;
        end else begin
            outstanding <= out_next;
            stale_cnt   <= stale_next;
            hold_stale  <= hold_stale_next;
            ar_hold     <= ifu_ARVALID && !ifu_ARREADY;
            if (ifu_ARVALID && !ifu_ARREADY)
                hold_addr <= ar_addr_sel;
            case (state)
                IDLE: begin
                    state    <= FETCH;
                    fetch_pc <= RST_PC;
                    rsp_pc   <= RST_PC;
                end
                FETCH: begin
                    if (redirect_act) begin
                        fetch_pc <= redirect_aligned;
                        rsp_pc   <= redirect_aligned;
                        state    <= ((stale_next != '0) || hold_stale_next) ? DRAIN : FETCH;
                    end else begin
                        if (ar_fire)
                            fetch_pc <= fetch_pc + AW'(4);
                        if (push)
                            rsp_pc <= rsp_pc + AW'(4);
                    end
                end
                DRAIN: begin
                    if (redirect_act) begin
                        fetch_pc <= redirect_aligned;
                        rsp_pc   <= redirect_aligned;
                    end else if ((stale_next == '0) && !hold_stale_next) begin
                        state <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Lane-select queue pointers, one entry per issued request in issue order.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            lq_wr <= '0;
            lq_rd <= '0;
        end else begin
            if (ar_fire)
                lq_wr <= lq_wr + 1'b1;
            if (r_fire)
                lq_rd <= lq_rd + 1'b1;
        end
    end

    // Record address bit 2 of each issued request to pick the RDATA half later.
    always_ff @(posedge clk) begin
        if (ar_fire)
            lane_q[lq_wr] <= ar_addr_sel[2];
    end

    // Prefetch FIFO pointers; a redirect empties the FIFO after any same-cycle pop.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr <= '0;
            rptr <= '0;
        end else if (redirect_act) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
        end
    end

    // Prefetch FIFO storage write.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wptr[PW-1:0]]    <= rsp_pc;
            instr_mem[wptr[PW-1:0]] <= push_instr;
            err_mem[wptr[PW-1:0]]   <= r_err;
        end
    end

endmodule

// File: tb/tb_ifu_prefetch.sv
// tb_ifu_prefetch: directed bench for ifu_prefetch with a small in-order
// memory responder (automatic 1-cycle latency or manually released beats).
module tb_ifu_prefetch;

    logic        clk = 1'b0;
    logic        rstn;
    logic        ifu_ARVALID;
    logic        ifu_ARREADY;
    logic [63:0] ifu_ARADDR;
    logic [2:0]  ifu_ARPORT;
    logic        ifu_RVALID;
    logic        ifu_RREADY;
    logic [63:0] ifu_RDATA;
    logic [1:0]  ifu_RRESP;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        instr_err;

    int errors = 0;
    int checks = 0;
    bit autoResp;
    logic [63:0] errAddr;
    logic [63:0] pendQ[$];
    logic [63:0] arLog[$];

    ifu_prefetch dut (
        .clk(clk), .rstn(rstn),
        .ifu_ARVALID(ifu_ARVALID), .ifu_ARREADY(ifu_ARREADY), .ifu_ARADDR(ifu_ARADDR),
        .ifu_ARPORT(ifu_ARPORT), .ifu_RVALID(ifu_RVALID), .ifu_RREADY(ifu_RREADY),
        .ifu_RDATA(ifu_RDATA), .ifu_RRESP(ifu_RRESP),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .instr_pc(instr_pc), .instr_err(instr_err)
    );

    always #5 clk = ~clk;

    // Memory contents model: two known opcodes at the reset PC, a pattern elsewhere.
    function automatic logic [31:0] instrOf(input logic [63:0] a);
        if (a == 64'h8000_0000)      return 32'h0010_0093;
        else if (a == 64'h8000_0004) return 32'h0020_0113;
        else                         return a[31:0] ^ 32'h5A5A_0000;
    endfunction

    // Present the oldest outstanding request's 8-byte beat on the R channel.
    task automatic driveBeat();
        logic [63:0] a;
        a = pendQ.pop_front();
        ifu_RVALID = 1'b1;
        ifu_RDATA  = {instrOf({a[63:3], 3'b100}), instrOf({a[63:3], 3'b000})};
        ifu_RRESP  = (a == errAddr) ? 2'b10 : 2'b00;
    endtask

    // One clock: log any AR handshake, clear pulses, then drive the next R beat.
    task automatic applyStimulus();
        logic        fire;
        logic [63:0] a;
        fire = ifu_ARVALID && ifu_ARREADY;
        a    = ifu_ARADDR;
        @(posedge clk);
        #1;
        if (fire) begin
            pendQ.push_back(a);
            arLog.push_back(a);
        end
        redirect_valid = 1'b0;
        ifu_RVALID = 1'b0;
        ifu_RDATA  = '0;
        ifu_RRESP  = 2'b00;
        if (autoResp && pendQ.size() > 0)
            driveBeat();
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One-cycle reset pulse; afterwards the DUT sits in its first IDLE cycle.
    task automatic doReset();
        rstn = 1'b0;
        applyStimulus();
        rstn = 1'b1;
        pendQ.delete();
        arLog.delete();
        ifu_RVALID = 1'b0;
        ifu_RDATA  = '0;
        ifu_RRESP  = 2'b00;
        redirect_valid = 1'b0;
    endtask

    task automatic checkResetValues(input string pfx);
        checkOutput({pfx, "_arvalid"}, 64'(ifu_ARVALID), 64'd0);
        checkOutput({pfx, "_araddr"},  ifu_ARADDR, 64'd0);
        checkOutput({pfx, "_arport"},  64'(ifu_ARPORT), 64'd0);
        checkOutput({pfx, "_ivalid"},  64'(instr_valid), 64'd0);
        checkOutput({pfx, "_instr"},   64'(instr), 64'd0);
        checkOutput({pfx, "_ipc"},     instr_pc, 64'd0);
        checkOutput({pfx, "_ierr"},    64'(instr_err), 64'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rstn = 1'b0;
        ifu_ARREADY = 1'b1;
        ifu_RVALID = 1'b0;
        ifu_RDATA = '0;
        ifu_RRESP = 2'b00;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b1;
        autoResp = 1'b1;
        errAddr = '1;

        // Reset values and first fetches with 1-cycle memory latency
        repeat (2) applyStimulus();
        checkResetValues("rst");
        checkOutput("rst_rready", 64'(ifu_RREADY), 64'd1);
        rstn = 1'b1;
        pendQ.delete();
        arLog.delete();
        checkOutput("idle_arvalid", 64'(ifu_ARVALID), 64'd0);
        applyStimulus();
        checkOutput("c1_arvalid", 64'(ifu_ARVALID), 64'd1);
        checkOutput("c1_araddr", ifu_ARADDR, 64'h8000_0000);
        checkOutput("c1_arport", 64'(ifu_ARPORT), 64'd4);
        applyStimulus();
        checkOutput("c2_araddr", ifu_ARADDR, 64'h8000_0004);
        checkOutput("c2_ivalid", 64'(instr_valid), 64'd0);
        applyStimulus();
        checkOutput("c3_ivalid", 64'(instr_valid), 64'd1);
        checkOutput("c3_instr", 64'(instr), 64'h0010_0093);
        checkOutput("c3_ipc", instr_pc, 64'h8000_0000);
        checkOutput("c3_ierr", 64'(instr_err), 64'd0);
        applyStimulus();
        checkOutput("c4_ivalid", 64'(instr_valid), 64'd1);
        checkOutput("c4_instr", 64'(instr), 64'h0020_0113);
        checkOutput("c4_ipc", instr_pc, 64'h8000_0004);
        applyStimulus();
        checkOutput("c5_ipc", instr_pc, 64'h8000_0008);
        checkOutput("c5_instr", 64'(instr), 64'(instrOf(64'h8000_0008)));

        // Decoder stalled: credit limit of DEPTH=4, then one pop frees one slot
        instr_ready = 1'b0;
        doReset();
        repeat (10) applyStimulus();
        checkOutput("bp_arcount", 64'(arLog.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            checkOutput("bp_araddr", arLog[i], 64'h8000_0000 + 64'(4 * i));
        checkOutput("bp_arvalid_off", 64'(ifu_ARVALID), 64'd0);
        checkOutput("bp_head", instr_pc, 64'h8000_0000);
        instr_ready = 1'b1;
        applyStimulus();
        instr_ready = 1'b0;
        checkOutput("bp_pop_arvalid", 64'(ifu_ARVALID), 64'd1);
        checkOutput("bp_pop_araddr", ifu_ARADDR, 64'h8000_0010);
        checkOutput("bp_pop_head", instr_pc, 64'h8000_0004);
        repeat (3) applyStimulus();
        checkOutput("bp_arcount2", 64'(arLog.size()), 64'd5);
        checkOutput("bp_arvalid_off2", 64'(ifu_ARVALID), 64'd0);

        // Redirect with 3 requests in flight: drain them, then fetch the target
        instr_ready = 1'b1;
        autoResp = 1'b0;
        doReset();
        repeat (3) applyStimulus();
        checkOutput("dr_araddr3", ifu_ARADDR, 64'h8000_0008);
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_1000;
        applyStimulus();
        checkOutput("dr_arvalid", 64'(ifu_ARVALID), 64'd0);
        checkOutput("dr_ivalid", 64'(instr_valid), 64'd0);
        checkOutput("dr_pending", 64'(pendQ.size()), 64'd3);
        applyStimulus();
        checkOutput("dr_arvalid_wait", 64'(ifu_ARVALID), 64'd0);
        for (int i = 0; i < 3; i++) begin
            driveBeat();
            applyStimulus();
            checkOutput("dr_beat_ivalid", 64'(instr_valid), 64'd0);
            if (i < 2)
                checkOutput("dr_beat_noar", 64'(ifu_ARVALID), 64'd0);
        end
        checkOutput("dr_new_arvalid", 64'(ifu_ARVALID), 64'd1);
        checkOutput("dr_new_araddr", ifu_ARADDR, 64'h8000_1000);
        autoResp = 1'b1;
        repeat (2) applyStimulus();
        checkOutput("dr_new_ivalid", 64'(instr_valid), 64'd1);
        checkOutput("dr_new_ipc", instr_pc, 64'h8000_1000);
        checkOutput("dr_new_instr", 64'(instr), 64'(instrOf(64'h8000_1000)));

        // Redirect while an AR is waiting for ARREADY: old address completes, response dropped
        ifu_ARREADY = 1'b0;
        doReset();
        applyStimulus();
        checkOutput("hd_arvalid", 64'(ifu_ARVALID), 64'd1);
        checkOutput("hd_araddr", ifu_ARADDR, 64'h8000_0000);
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_2000;
        applyStimulus();
        checkOutput("hd_hold_arvalid", 64'(ifu_ARVALID), 64'd1);
        checkOutput("hd_hold_araddr", ifu_ARADDR, 64'h8000_0000);
        applyStimulus();
        checkOutput("hd_hold_araddr2", ifu_ARADDR, 64'h8000_0000);
        ifu_ARREADY = 1'b1;
        applyStimulus();
        checkOutput("hd_drain_arvalid", 64'(ifu_ARVALID), 64'd0);
        checkOutput("hd_drain_ivalid", 64'(instr_valid), 64'd0);
        applyStimulus();
        checkOutput("hd_new_araddr", ifu_ARADDR, 64'h8000_2000);
        checkOutput("hd_new_arvalid", 64'(ifu_ARVALID), 64'd1);
        checkOutput("hd_stale_ivalid", 64'(instr_valid), 64'd0);
        repeat (2) applyStimulus();
        checkOutput("hd_new_ivalid", 64'(instr_valid), 64'd1);
        checkOutput("hd_new_ipc", instr_pc, 64'h8000_2000);
        checkOutput("hd_new_instr", 64'(instr), 64'(instrOf(64'h8000_2000)));

        // Error response on 0x80000008
        errAddr = 64'h8000_0008;
        instr_ready = 1'b0;
        doReset();
        repeat (8) applyStimulus();
        checkOutput("er_arcount", 64'(arLog.size()), 64'd4);
        instr_ready = 1'b1;
        checkOutput("er_head0", instr_pc, 64'h8000_0000);
        checkOutput("er_err0", 64'(instr_err), 64'd0);
        applyStimulus();
        checkOutput("er_head1", instr_pc, 64'h8000_0004);
        applyStimulus();
        checkOutput("er_head2", instr_pc, 64'h8000_0008);
`ifdef IFU_PREFETCH_RESP_ERR_EN
        checkOutput("er_err2", 64'(instr_err), 64'd1);
        checkOutput("er_instr2", 64'(instr), 64'h0000_0013);
`else
        checkOutput("er_err2", 64'(instr_err), 64'd0);
        checkOutput("er_instr2", 64'(instr), 64'(instrOf(64'h8000_0008)));
`endif
        applyStimulus();
        checkOutput("er_head3", instr_pc, 64'h8000_000C);
        checkOutput("er_instr3", 64'(instr), 64'(instrOf(64'h8000_000C)));
        applyStimulus();
`ifdef IFU_PREFETCH_RESP_ERR_EN
        repeat (3) applyStimulus();
        checkOutput("er_stop_ivalid", 64'(instr_valid), 64'd0);
        checkOutput("er_stop_arvalid", 64'(ifu_ARVALID), 64'd0);
        checkOutput("er_stop_arcount", 64'(arLog.size()), 64'd4);
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_3000;
        applyStimulus();
        checkOutput("er_resume_arvalid", 64'(ifu_ARVALID), 64'd1);
        checkOutput("er_resume_araddr", ifu_ARADDR, 64'h8000_3000);
`else
        checkOutput("er_head4", instr_pc, 64'h8000_0010);
        checkOutput("er_instr4", 64'(instr), 64'(instrOf(64'h8000_0010)));
`endif

        // Reset pulse mid-stream with 3 FIFO entries, then refetch from RST_PC
        errAddr = '1;
        instr_ready = 1'b0;
        ifu_ARREADY = 1'b1;
        doReset();
        repeat (4) applyStimulus();
        ifu_ARREADY = 1'b0;
        applyStimulus();
        checkOutput("mr_ivalid", 64'(instr_valid), 64'd1);
        checkOutput("mr_ipc", instr_pc, 64'h8000_0000);
        checkOutput("mr_arvalid_held", 64'(ifu_ARVALID), 64'd1);
        rstn = 1'b0;
        applyStimulus();
        checkResetValues("mr");
        rstn = 1'b1;
        ifu_ARREADY = 1'b1;
        pendQ.delete();
        arLog.delete();
        ifu_RVALID = 1'b0;
        applyStimulus();
        checkOutput("mr_re_arvalid", 64'(ifu_ARVALID), 64'd1);
        checkOutput("mr_re_araddr", ifu_ARADDR, 64'h8000_0000);
        repeat (2) applyStimulus();
        checkOutput("mr_re_ivalid", 64'(instr_valid), 64'd1);
        checkOutput("mr_re_instr", 64'(instr), 64'h0010_0093);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ifu_prefetch.md
# ifu_prefetch

Parametrised instruction-fetch unit with a prefetch FIFO and multiple outstanding reads. It replaces the single-request fetch state machine in the core controller. It issues sequential fetch requests on the AXI-lite-style AR/R channel and buffers returned instructions for the decoder. It also handles PC redirects from branches and jumps by flushing the FIFO and discarding stale in-flight responses.

## Interface
Parameters:
- AW, 64, fetch address width.
- IW, 32, instruction width; must be 32.
- DEPTH, 4, FIFO depth and outstanding-read limit; power of 2, at least 2.
- RST_PC, 64'h8000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock; single clock domain.
- rstn  in  1  reset, synchronous, active-low.
- ifu_ARVALID  out  1  read address valid.
- ifu_ARREADY  in  1  read address ready.
- ifu_ARADDR  out  AW  fetch address; always 4-byte aligned.
- ifu_ARPORT  out  3  protection; 3'b100 (instruction) whenever ARVALID=1, else 0.
- ifu_RVALID  in  1  read data valid.
- ifu_RREADY  out  1  read data ready; constant 1.
- ifu_RDATA  in  64  read data, 8-byte beat.
- ifu_RRESP  in  2  response code; 2'b00 is OKAY.
- redirect_valid  in  1  redirect request, one-cycle pulse.
- redirect_pc  in  AW  new fetch PC; 4-byte aligned.
- instr_valid  out  1  FIFO head valid.
- instr_ready  in  1  decoder accepts the head.
- instr  out  IW  head instruction.
- instr_pc  out  AW  PC of the head instruction.
- instr_err  out  1  head carries a bus error.

## Operation
- FSM states: IDLE, FETCH, DRAIN. Reset enters IDLE. IDLE moves to FETCH unconditionally after 1 cycle, loading fetch_pc=RST_PC.
- FETCH issue rule: assert ARVALID when fifo_count + outstanding < DEPTH, with ARADDR=fetch_pc.
  - Once ARVALID is asserted, ARVALID and ARADDR stay stable until ARREADY, even across a redirect.
  - On the AR handshake: fetch_pc += 4 and outstanding++.
- R handshake (RVALID): outstanding-- and the RDATA lane is selected by the request address bit 2: 0 gives RDATA[31:0], 1 gives RDATA[63:32].
  - A per-request address-bit-2 queue of depth DEPTH tracks the lane for each outstanding request.
  - The selected instruction, its PC and its error flag are pushed into the FIFO unless the response is stale.
- FIFO: DEPTH entries of {pc, instr, err} with registered read and write pointers of width log2(DEPTH)+1.
  - Pop on instr_valid & instr_ready.
  - Push and pop in the same cycle are allowed at any occupancy.
  - Overflow cannot occur because of the issue-credit rule.
- Redirect, in any state except IDLE:
  - FIFO is flushed and fetch_pc <= redirect_pc.
  - All outstanding requests, including one whose AR handshake completes in the redirect cycle, are marked stale.
  - If ARVALID is pending without ARREADY, it completes with the old address and that request becomes stale.
  - If the stale count is 0, stay in/enter FETCH; otherwise go to DRAIN.
- DRAIN: no new AR is issued and R responses are discarded. Go to FETCH in the cycle after outstanding reaches 0.
  - A redirect during DRAIN only updates fetch_pc and stays in DRAIN.
- Simultaneous pop and redirect: the pop completes, since the decoder consumed the old head; the flush then applies.
- Simultaneous R and redirect: the response counts as stale and is discarded.

## Timing
- Reset values: ARVALID=0, ARADDR=0, ARPORT=0, instr_valid=0, instr=0, instr_pc=0, instr_err=0, outstanding=0, FIFO empty.
- Reset asserted mid-operation clears all state the next cycle; responses to pre-reset requests are the interconnect's responsibility.
- Cycle 0 after rstn rises: IDLE. Cycle 1: ARVALID=1, ARADDR=RST_PC.
- With ARREADY held high, a new AR is issued every cycle up to DEPTH outstanding.
- An R beat at cycle t gives instr_valid=1 at cycle t+1 (registered FIFO).
- Redirect at cycle t: instr_valid=0 at t+1.
  - If no request is outstanding, the first AR for redirect_pc is issued at t+1.
  - Otherwise it is issued the cycle after the last stale R beat.
- Sustained throughput is 1 instruction/cycle when the memory returns R one cycle after AR and DEPTH is at least 2.

## Configuration
- IFU_PREFETCH_RESP_ERR_EN defined:
  - RRESP != 2'b00 pushes an entry with instr_err=1 and instr=32'h0000_0013 (NOP).
  - After such a push, fetching stops (no further AR) until a redirect.
- Not defined: RRESP is ignored, instr_err is tied to 0, and data is pushed unconditionally.

## Test plan
- Reset release, ARREADY=1, 1-cycle R latency returning 0x00100093/0x00200113 for 0x80000000/0x80000004 -> instr_pc 0x80000000 then 0x80000004, back-to-back instr_valid, correct lane select.
- instr_ready=0 with DEPTH=4 -> exactly 4 AR handshakes (0x80000000..0x8000000C), then ARVALID=0; one pop -> one new AR to 0x80000010.
- 3 outstanding requests, redirect to 0x80001000 -> state DRAIN, 3 R beats dropped, instr_valid stays 0, next AR to 0x80001000 one cycle after the last beat.
- ARVALID pending with ARREADY=0 when redirect arrives -> ARADDR stays unchanged until the handshake, that response is dropped, then AR to the redirect target.
- With the macro defined, RRESP=2'b10 for 0x80000008 -> entry instr_err=1, instr=0x00000013, no further AR until redirect. Without the macro -> RDATA delivered, instr_err=0.
- rstn low for 1 cycle mid-stream with FIFO holding 3 entries -> all outputs return to reset values the next cycle, and refetch starts at 0x80000000.
